// File: rtl/dummy_master_sequencer.sv
// Kicks a bank of dummy AXI masters strictly one at a time, in index order, for a
// programmable number of passes, collecting per-master error and timeout flags.
module dummy_master_sequencer #(
   parameter int unsigned NUM_MASTERS    = 2,
   parameter int unsigned INIT_PULSE     = 2,
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter int unsigned LOOP_W         = 8,
   parameter bit          STOP_ON_FAIL   = 1'b0
) (
   input  logic                   ACLK,
   input  logic                   ARESETN,
   input  logic                   start,
   input  logic [LOOP_W-1:0]      loop_count,
   output logic [NUM_MASTERS-1:0] m_init_txn,
   input  logic [NUM_MASTERS-1:0] m_txn_done,
   input  logic [NUM_MASTERS-1:0] m_error,
   output logic                   busy,
   output logic                   done,
   output logic                   fail,
   output logic [NUM_MASTERS-1:0] error_mask,
   output logic [NUM_MASTERS-1:0] timeout_mask,
   output logic [LOOP_W-1:0]      iter_count
);
   localparam int unsigned IDX_W   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int unsigned CNT_MAX = (INIT_PULSE > TIMEOUT_CYCLES) ? INIT_PULSE : TIMEOUT_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_MASTERS - 1);
   localparam logic [CNT_W-1:0]  PULSE_END = CNT_W'(INIT_PULSE - 1);
   localparam logic [CNT_W-1:0]  TMO_END   = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [LOOP_W-1:0] ITER_MAX  = '1;

   typedef enum logic [2:0] {StIdle, StKick, StWait, StAdvance, StFinish} state_e;

   state_e                  r_state, w_state_nxt;
   logic [IDX_W-1:0]        r_idx, w_idx_nxt;
   logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
   logic [LOOP_W-1:0]       r_loops, w_loops_nxt;
   logic [LOOP_W-1:0]       r_iter, w_iter_nxt;
   logic                    r_fail, w_fail_nxt;
   logic [NUM_MASTERS-1:0]  r_err, w_err_nxt;
   logic [NUM_MASTERS-1:0]  r_tmo, w_tmo_nxt;
   logic                    r_done_prev;
   logic                    w_done_cur;
   logic                    w_done_rise;
   logic [LOOP_W-1:0]       w_iter_inc;

   // r_done_prev tracks the selected master through KICK, so a level already high on
   // WAIT entry is never mistaken for a completion edge.
   assign w_done_cur  = m_txn_done[r_idx];
   assign w_done_rise = (r_state == StWait) && w_done_cur && !r_done_prev;
   assign w_iter_inc  = (r_iter == ITER_MAX) ? r_iter : r_iter + LOOP_W'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
      w_loops_nxt = r_loops;
      w_iter_nxt  = r_iter;
      w_fail_nxt  = r_fail;
      w_err_nxt   = r_err;
      w_tmo_nxt   = r_tmo;
      unique case (r_state)
         StIdle: begin
            if (start) begin
               w_loops_nxt = (loop_count == '0) ? LOOP_W'(1) : loop_count;
               w_iter_nxt  = '0;
               w_fail_nxt  = 1'b0;
               w_err_nxt   = '0;
               w_tmo_nxt   = '0;
               w_idx_nxt   = '0;
               w_cnt_nxt   = '0;
               w_state_nxt = StKick;
            end
         end
         StKick: begin
            if (r_cnt == PULSE_END) begin
               w_cnt_nxt   = '0;
               w_state_nxt = StWait;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         StWait: begin
            // A completion edge beats a timeout landing in the same cycle.
            if (w_done_rise) begin
               if (m_error[r_idx]) begin
                  w_err_nxt[r_idx] = 1'b1;
                  w_fail_nxt       = 1'b1;
               end
               w_cnt_nxt   = '0;
               w_state_nxt = StAdvance;
            end else if (r_cnt == TMO_END) begin
               w_tmo_nxt[r_idx] = 1'b1;
               w_fail_nxt       = 1'b1;
               w_cnt_nxt        = '0;
               w_state_nxt      = StAdvance;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         StAdvance: begin
            if (STOP_ON_FAIL && r_fail) begin
               w_state_nxt = StFinish;
            end else if (r_idx != LAST_IDX) begin
               w_idx_nxt   = r_idx + 1'b1;
               w_state_nxt = StKick;
            end else begin
               w_iter_nxt = w_iter_inc;
               w_idx_nxt  = '0;
               if (w_iter_inc == r_loops) begin
                  w_state_nxt = StFinish;
               end else begin
                  w_state_nxt = StKick;
               end
            end
         end
         StFinish: w_state_nxt = StIdle;
         default:  w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_state     <= StIdle;
         r_idx       <= '0;
         r_cnt       <= '0;
         r_loops     <= '0;
         r_iter      <= '0;
         r_fail      <= 1'b0;
         r_err       <= '0;
         r_tmo       <= '0;
         r_done_prev <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_idx       <= w_idx_nxt;
         r_cnt       <= w_cnt_nxt;
         r_loops     <= w_loops_nxt;
         r_iter      <= w_iter_nxt;
         r_fail      <= w_fail_nxt;
         r_err       <= w_err_nxt;
         r_tmo       <= w_tmo_nxt;
         r_done_prev <= w_done_cur;
      end
   end

   // Decoded from the async-reset state register, so reset drops the kick immediately.
   always_comb begin
      m_init_txn = '0;
      if (r_state == StKick) m_init_txn[r_idx] = 1'b1;
   end

   assign busy         = (r_state == StKick) || (r_state == StWait) || (r_state == StAdvance);
   assign done         = (r_state == StFinish);
   assign fail         = r_fail;
   assign error_mask   = r_err;
   assign timeout_mask = r_tmo;
   assign iter_count   = r_iter;

endmodule

// File: tb/tb_dummy_master_sequencer.sv
// Scoreboard bench: directed runs push expected kick/done events; a monitor pops and
// compares them as the sequencer presents init pulses and done pulses.
module tb_dummy_master_sequencer;
   localparam int unsigned NM  = 2;
   localparam int unsigned IP  = 2;
   localparam int unsigned TMO = 64;
   localparam int unsigned LW  = 8;

   typedef struct {
      bit          is_done;
      int          idx;
      bit          fail;
      logic [1:0]  err;
      logic [1:0]  tmo;
      logic [7:0]  iter;
      int          gap_d;   // cycles since last TXN_DONE rise, 0 = unchecked
      int          gap_k;   // cycles since previous kick, 0 = unchecked
   } exp_t;

   logic          clk = 1'b0;
   logic          ARESETN = 1'b0;
   logic          start = 1'b0;
   logic          sel = 1'b0;
   logic [LW-1:0] loop_count = '0;
   logic          m_done_u [NM];
   logic          m_err_u [NM];
   wire  [NM-1:0] w_m_done = {m_done_u[1], m_done_u[0]};
   wire  [NM-1:0] w_m_err  = {m_err_u[1], m_err_u[0]};

   logic [NM-1:0] a_init, b_init, a_err, b_err, a_tmo, b_tmo;
   logic          a_busy, b_busy, a_done, b_done, a_fail, b_fail;
   logic [LW-1:0] a_iter, b_iter;
   wire           w_start_a = start & ~sel;
   wire           w_start_b = start & sel;

   wire [NM-1:0] w_init_any = a_init | b_init;
   wire [NM-1:0] w_init  = sel ? b_init : a_init;
   wire          w_busy  = sel ? b_busy : a_busy;
   wire          w_doneo = sel ? b_done : a_done;
   wire          w_fail  = sel ? b_fail : a_fail;
   wire [NM-1:0] w_err   = sel ? b_err  : a_err;
   wire [NM-1:0] w_tmo   = sel ? b_tmo  : a_tmo;
   wire [LW-1:0] w_iter  = sel ? b_iter : a_iter;

   dummy_master_sequencer #(
      .NUM_MASTERS(NM), .INIT_PULSE(IP), .TIMEOUT_CYCLES(TMO), .LOOP_W(LW), .STOP_ON_FAIL(1'b0)
   ) u_dut (
      .ACLK(clk), .ARESETN(ARESETN), .start(w_start_a), .loop_count(loop_count),
      .m_init_txn(a_init), .m_txn_done(w_m_done), .m_error(w_m_err), .busy(a_busy),
      .done(a_done), .fail(a_fail), .error_mask(a_err), .timeout_mask(a_tmo),
      .iter_count(a_iter)
   );

   dummy_master_sequencer #(
      .NUM_MASTERS(NM), .INIT_PULSE(IP), .TIMEOUT_CYCLES(TMO), .LOOP_W(LW), .STOP_ON_FAIL(1'b1)
   ) u_dut_sof (
      .ACLK(clk), .ARESETN(ARESETN), .start(w_start_b), .loop_count(loop_count),
      .m_init_txn(b_init), .m_txn_done(w_m_done), .m_error(w_m_err), .busy(b_busy),
      .done(b_done), .fail(b_fail), .error_mask(b_err), .timeout_mask(b_tmo),
      .iter_count(b_iter)
   );

   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t exp_q [$];

   // Master behaviour: 0 = done pulse, 1 = never done, 2 = done level left high
   int dly [NM]    = '{20, 20};
   int mode [NM]   = '{0, 0};
   int err_at [NM] = '{-1, -1};
   int kick_n [NM];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic push_kick(input int idx, input int gd, input int gk);
      exp_t e;
      e = '{is_done: 1'b0, idx: idx, fail: 1'b0, err: 2'b00, tmo: 2'b00, iter: 8'd0,
            gap_d: gd, gap_k: gk};
      exp_q.push_back(e);
   endtask

   task automatic push_done(input bit f, input logic [1:0] er, input logic [1:0] tm,
                            input logic [7:0] it, input int gd);
      exp_t e;
      e = '{is_done: 1'b1, idx: 0, fail: f, err: er, tmo: tm, iter: it, gap_d: gd, gap_k: 0};
      exp_q.push_back(e);
   endtask

   task automatic do_start(input logic [LW-1:0] lc);
      @(negedge clk);
      loop_count = lc;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int i;
      i = 0;
      while (exp_q.size() != 0 && i < budget) begin
         @(negedge clk);
         i++;
      end
      chk(name, exp_q.size(), 0);
      exp_q.delete();
      repeat (4) @(negedge clk);
   endtask

   for (genvar g = 0; g < NM; g++) begin : g_resp
      initial begin
         m_done_u[g] = 1'b0;
         m_err_u[g]  = 1'b0;
         kick_n[g]   = 0;
         forever begin
            @(posedge w_init_any[g]);
            repeat (dly[g]) @(posedge clk);
            #2;
            if (mode[g] == 0) begin
               m_err_u[g]  = (kick_n[g] == err_at[g]);
               m_done_u[g] = 1'b1;
               repeat (3) @(posedge clk);
               #2;
               m_done_u[g] = 1'b0;
               m_err_u[g]  = 1'b0;
            end else if (mode[g] == 2) begin
               if (m_done_u[g]) begin
                  m_done_u[g] = 1'b0;
                  repeat (2) @(posedge clk);
                  #2;
               end
               m_done_u[g] = 1'b1;
            end
            kick_n[g]++;
         end
      end
   end

   // Monitor
   int            cyc = 0, last_drise = 0, last_kick = 0, pulse_len = 0;
   logic [NM-1:0] prev_init = '0, prev_mdone = '0;
   logic          prev_doneo = 1'b0;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (!ARESETN) begin
            prev_init  = '0;
            prev_doneo = 1'b0;
            prev_mdone = w_m_done;
            pulse_len  = 0;
         end else begin
            if ((w_m_done & ~prev_mdone) != '0) last_drise = cyc;
            prev_mdone = w_m_done;
            if (w_init != '0) begin
               if (prev_init == '0) begin
                  pulse_len = 1;
                  if (exp_q.size() == 0) begin
                     chk("unexpected_kick", w_init, 0);
                  end else begin
                     e = exp_q.pop_front();
                     chk("event_kind_kick", 32'(e.is_done), 0);
                     chk("kick_onehot_idx", 32'(w_init), 32'(1) << e.idx);
                     chk("kick_busy", 32'(w_busy), 1);
                     if (e.gap_k != 0) chk("kick_gap_from_kick", cyc - last_kick, e.gap_k);
                     if (e.gap_d != 0) chk("kick_gap_from_done", cyc - last_drise, e.gap_d);
                  end
                  last_kick = cyc;
               end else begin
                  pulse_len++;
               end
            end else if (prev_init != '0) begin
               chk("init_pulse_len", pulse_len, IP);
            end
            if (prev_doneo) chk("done_width", 32'(w_doneo), 0);
            if (w_doneo) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_done", 32'(w_doneo), 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("event_kind_done", 32'(e.is_done), 1);
                  chk("done_busy", 32'(w_busy), 0);
                  chk("done_fail", 32'(w_fail), 32'(e.fail));
                  chk("done_err_mask", 32'(w_err), 32'(e.err));
                  chk("done_tmo_mask", 32'(w_tmo), 32'(e.tmo));
                  chk("done_iter", 32'(w_iter), 32'(e.iter));
                  if (e.gap_d != 0) chk("done_gap_from_done", cyc - last_drise, e.gap_d);
               end
            end
            prev_init  = w_init;
            prev_doneo = w_doneo;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before 500000");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      repeat (2) @(negedge clk);
      chk("rst_init", 32'(a_init), 0);
      chk("rst_busy", 32'(a_busy), 0);
      chk("rst_done", 32'(a_done), 0);
      chk("rst_fail", 32'(a_fail), 0);
      chk("rst_masks", 32'({a_err, a_tmo}), 0);
      chk("rst_iter", 32'(a_iter), 0);
      chk("rst_sof_busy", 32'({b_busy, b_init}), 0);
      ARESETN = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_busy", 32'(a_busy), 0);

      // Single pass, both masters respond cleanly after ~50 cycles
      dly = '{50, 50};
      push_kick(0, 0, 0); push_kick(1, 2, 0); push_done(1'b0, 2'b00, 2'b00, 8'd1, 2);
      do_start(8'd1);
      wait_drain("drain_single_pass", 400);

      // Three passes, master1 errors on its second kick only
      dly = '{20, 20};
      err_at[1] = kick_n[1] + 1;
      push_kick(0, 0, 0);
      for (int i = 0; i < 5; i++) push_kick((i + 1) % 2, 2, 0);
      push_done(1'b1, 2'b10, 2'b00, 8'd3, 2);
      do_start(8'd3);
      wait_drain("drain_three_pass", 600);
      err_at[1] = -1;

      // Master0 silent: WAIT lasts TMO cycles, master1 still kicked
      mode[0] = 1;
      push_kick(0, 0, 0); push_kick(1, 0, IP + TMO + 1);
      push_done(1'b1, 2'b00, 2'b01, 8'd1, 2);
      do_start(8'd1);
      wait_drain("drain_timeout", 400);
      mode[0] = 0;

      // Stop-on-fail instance: master0 errors, master1 never kicked
      sel = 1'b1;
      err_at[0] = kick_n[0];
      push_kick(0, 0, 0); push_done(1'b1, 2'b01, 2'b00, 8'd0, 2);
      do_start(8'd2);
      wait_drain("drain_stop_on_fail", 400);
      err_at[0] = -1;
      sel = 1'b0;

      // Done levels left high; second run (loop_count 0) needs a fresh edge
      mode = '{2, 2};
      push_kick(0, 0, 0); push_kick(1, 2, 0); push_done(1'b0, 2'b00, 2'b00, 8'd1, 2);
      do_start(8'd1);
      wait_drain("drain_sticky_a", 400);
      push_kick(0, 0, 0); push_kick(1, 2, 0); push_done(1'b0, 2'b00, 2'b00, 8'd1, 2);
      do_start(8'd0);
      repeat (6) @(negedge clk);
      loop_count = 8'd5;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
      wait_drain("drain_sticky_b", 400);

      // Reset during master1's kick aborts the run without a done pulse
      push_kick(0, 0, 0); push_kick(1, 2, 0);
      do_start(8'd1);
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge clk);
         if (w_init[1]) found = 1'b1;
      end
      chk("reach_kick1", 32'(found), 1);
      #1 ARESETN = 1'b0;
      #1;
      chk("abort_init", 32'(a_init), 0);
      chk("abort_busy_done", 32'({a_busy, a_done}), 0);
      chk("abort_fail_masks", 32'({a_fail, a_err, a_tmo}), 0);
      chk("abort_iter", 32'(a_iter), 0);
      repeat (3) @(negedge clk);
      ARESETN = 1'b1;
      chk("abort_queue", exp_q.size(), 0);
      exp_q.delete();
      repeat (40) @(negedge clk);
      push_kick(0, 0, 0); push_kick(1, 2, 0); push_done(1'b0, 2'b00, 2'b00, 8'd1, 2);
      do_start(8'd1);
      wait_drain("drain_after_reset", 400);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
